// File: rtl/add64_issue_stage.sv
`default_nettype none
// ============================================================================
// Module  : add64_issue_stage
// Brief   : In-order operand issue queue feeding a registered 64-bit adder,
//           tracking an architectural carry flag.
// Revision: 1.0 - initial release
// ============================================================================
module add64_issue_stage #(
    parameter int DEPTH     = 4,
    parameter int ADDER_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_op,
    input  logic [63:0]              in_a,
    input  logic [63:0]              in_b,
    output logic [63:0]              a_o,
    output logic [63:0]              b_o,
    output logic                     cin_o,
    output logic                     issue_o,
    input  logic                     cout_r_i,
    output logic                     carry_flag_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     busy_o
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;
    localparam int c_OUT_W = $clog2(ADDER_LAT + 2) + 1;
    localparam logic [c_LVL_W-1:0] c_FULL_LVL = c_LVL_W'(DEPTH);

    logic [1:0]          r_op_mem [DEPTH];
    logic [63:0]         r_a_mem  [DEPTH];
    logic [63:0]         r_b_mem  [DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_LVL_W-1:0]  r_level;
    logic [c_OUT_W-1:0]  r_outstanding;
    logic [ADDER_LAT-1:0] r_pipe;
    logic [63:0]         r_a;
    logic [63:0]         r_b;
    logic                r_cin;
    logic                r_issue;
    logic                r_carry_flag;

    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_tap;
    logic [1:0]          w_head_op;

    assign w_full    = (r_level == c_FULL_LVL);
    assign w_empty   = (r_level == '0);
    assign in_ready  = !w_full && !rst;
    assign w_push    = in_valid && in_ready;
    assign w_head_op = r_op_mem[r_rd_ptr];
    assign w_tap     = r_pipe[ADDER_LAT-1];

    // op[1] marks carry consumers: they wait until no result is pending so the flag is final
    assign w_pop = !w_empty &&
                   (!w_head_op[1] || ((r_outstanding == '0) && !r_issue));

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_op_mem[r_wr_ptr] <= in_op;
            r_a_mem[r_wr_ptr]  <= in_a;
            r_b_mem[r_wr_ptr]  <= in_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_cin    <= 1'b0;
            r_issue  <= 1'b0;
        end else begin
            r_issue <= w_pop;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                r_a      <= r_a_mem[r_rd_ptr];
                r_b      <= w_head_op[0] ? ~r_b_mem[r_rd_ptr] : r_b_mem[r_rd_ptr];
                r_cin    <= w_head_op[1] ? r_carry_flag : w_head_op[0];
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LVL_W'(1);
                2'b01:   r_level <= r_level - c_LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Each issue bit travels ADDER_LAT stages; the last stage lines up with cout_r_i
    generate
        if (ADDER_LAT == 1) begin : g_pipe_single
            always_ff @(posedge clk) begin
                if (rst) r_pipe <= '0;
                else     r_pipe <= r_issue;
            end
        end else begin : g_pipe_multi
            always_ff @(posedge clk) begin
                if (rst) r_pipe <= '0;
                else     r_pipe <= {r_pipe[ADDER_LAT-2:0], r_issue};
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_outstanding <= '0;
            r_carry_flag  <= 1'b0;
        end else begin
            if (w_tap) begin
                r_carry_flag <= cout_r_i;
            end
            case ({r_issue, w_tap})
                2'b10:   r_outstanding <= r_outstanding + c_OUT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - c_OUT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    assign a_o          = r_a;
    assign b_o          = r_b;
    assign cin_o        = r_cin;
    assign issue_o      = r_issue;
    assign carry_flag_o = r_carry_flag;
    assign level_o      = r_level;
    assign busy_o       = (r_level != '0) || (r_outstanding != '0) || r_issue;

endmodule
`default_nettype wire

// File: tb/tb_add64_issue_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_add64_issue_stage
// Brief   : Directed self-checking bench for add64_issue_stage with a
//           registered-carry adder model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_add64_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic [63:0] a_o;
    logic [63:0] b_o;
    logic        cin_o;
    logic        issue_o;
    logic        cout_r_i;
    logic        carry_flag_o;
    logic [2:0]  level_o;
    logic        busy_o;

    logic [64:0] r_sum;
    logic        force_cout;
    int          n_vec = 0;
    int          n_err = 0;

    localparam logic [1:0] c_ADD = 2'b00;
    localparam logic [1:0] c_SUB = 2'b01;
    localparam logic [1:0] c_ADC = 2'b10;
    localparam logic [1:0] c_SBB = 2'b11;
    localparam logic [63:0] c_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    always #5 clk = ~clk;

    add64_issue_stage #(.DEPTH(4), .ADDER_LAT(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_a         (in_a),
        .in_b         (in_b),
        .a_o          (a_o),
        .b_o          (b_o),
        .cin_o        (cin_o),
        .issue_o      (issue_o),
        .cout_r_i     (cout_r_i),
        .carry_flag_o (carry_flag_o),
        .level_o      (level_o),
        .busy_o       (busy_o)
    );

    // Registered adder: carry-out of this cycle's operands appears next cycle
    always @(posedge clk) r_sum <= {1'b0, a_o} + {1'b0, b_o} + {64'd0, cin_o};
    assign cout_r_i = r_sum[64] | force_cout;

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
        in_valid = v;
        in_op    = op;
        in_a     = a;
        in_b     = b;
    endtask

    initial begin
        rst = 1'b1;
        force_cout = 1'b0;
        drive(1'b0, c_ADD, 64'd0, 64'd0);
        tick;
        tick;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_issue",    {63'd0, issue_o}, 64'd0);
        chk("rst_a",        a_o, 64'd0);
        chk("rst_b",        b_o, 64'd0);
        chk("rst_cin",      {63'd0, cin_o}, 64'd0);
        chk("rst_flag",     {63'd0, carry_flag_o}, 64'd0);
        chk("rst_level",    {61'd0, level_o}, 64'd0);
        chk("rst_busy",     {63'd0, busy_o}, 64'd0);
        rst = 1'b0;

        // c0: ADD all-ones + 1
        tick;
        chk("c0_in_ready", {63'd0, in_ready}, 64'd1);
        chk("c0_level",    {61'd0, level_o}, 64'd0);
        drive(1'b1, c_ADD, c_ONES, 64'd1);
        tick;   // c1: ADC 5 + 7 back-to-back
        chk("c1_level", {61'd0, level_o}, 64'd1);
        chk("c1_issue", {63'd0, issue_o}, 64'd0);
        drive(1'b1, c_ADC, 64'd5, 64'd7);
        tick;   // c2
        chk("add_issue", {63'd0, issue_o}, 64'd1);
        chk("add_a",     a_o, c_ONES);
        chk("add_b",     b_o, 64'd1);
        chk("add_cin",   {63'd0, cin_o}, 64'd0);
        chk("c2_level",  {61'd0, level_o}, 64'd1);
        drive(1'b0, c_ADD, 64'd0, 64'd0);
        tick;   // c3
        chk("c3_cout",   {63'd0, cout_r_i}, 64'd1);
        chk("c3_flag",   {63'd0, carry_flag_o}, 64'd0);
        chk("c3_issue",  {63'd0, issue_o}, 64'd0);
        tick;   // c4
        chk("c4_flag",   {63'd0, carry_flag_o}, 64'd1);
        chk("c4_issue",  {63'd0, issue_o}, 64'd0);
        tick;   // c5: ADC issues three cycles after ADD
        chk("adc_issue", {63'd0, issue_o}, 64'd1);
        chk("adc_a",     a_o, 64'd5);
        chk("adc_b",     b_o, 64'd7);
        chk("adc_cin",   {63'd0, cin_o}, 64'd1);
        chk("adc_sum",   a_o + b_o + {63'd0, cin_o}, 64'd13);
        tick;   // c6
        tick;   // c7: 5+7+1 produces no carry
        chk("c7_flag",   {63'd0, carry_flag_o}, 64'd0);
        chk("c7_busy",   {63'd0, busy_o}, 64'd0);
        drive(1'b1, c_SBB, 64'd0, 64'd0);
        tick;   // c8
        chk("c8_level",  {61'd0, level_o}, 64'd1);
        drive(1'b1, c_SUB, 64'd10, 64'd3);
        tick;   // c9
        chk("sbb_issue", {63'd0, issue_o}, 64'd1);
        chk("sbb_a",     a_o, 64'd0);
        chk("sbb_b",     b_o, c_ONES);
        chk("sbb_cin",   {63'd0, cin_o}, 64'd0);
        drive(1'b0, c_ADD, 64'd0, 64'd0);
        tick;   // c10
        chk("sub_issue", {63'd0, issue_o}, 64'd1);
        chk("sub_a",     a_o, 64'd10);
        chk("sub_b",     b_o, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("sub_cin",   {63'd0, cin_o}, 64'd1);
        tick;   // c11: SBB 0 - 0 - borrow leaves carry clear
        chk("c11_flag",  {63'd0, carry_flag_o}, 64'd0);
        tick;   // c12: SUB 10 - 3 sets carry (no borrow)
        chk("c12_flag",  {63'd0, carry_flag_o}, 64'd1);

        // Fill: continuous ADC stream, each ADC waits for its predecessor
        drive(1'b1, c_ADC, 64'd1, 64'd1);
        tick;   // c13
        chk("c13_level", {61'd0, level_o}, 64'd1);
        tick;   // c14
        chk("c14_issue", {63'd0, issue_o}, 64'd1);
        chk("c14_level", {61'd0, level_o}, 64'd1);
        tick;   // c15
        chk("c15_level", {61'd0, level_o}, 64'd2);
        chk("c15_issue", {63'd0, issue_o}, 64'd0);
        tick;   // c16
        chk("c16_level", {61'd0, level_o}, 64'd3);
        tick;   // c17
        chk("c17_issue", {63'd0, issue_o}, 64'd1);
        chk("c17_level", {61'd0, level_o}, 64'd3);
        tick;   // c18
        chk("full_level",    {61'd0, level_o}, 64'd4);
        chk("full_in_ready", {63'd0, in_ready}, 64'd0);
        chk("full_busy",     {63'd0, busy_o}, 64'd1);
        tick;   // c19: pop while full, push refused
        chk("c19_level",     {61'd0, level_o}, 64'd4);
        chk("c19_in_ready",  {63'd0, in_ready}, 64'd0);
        tick;   // c20
        chk("c20_level",     {61'd0, level_o}, 64'd3);
        chk("c20_issue",     {63'd0, issue_o}, 64'd1);
        drive(1'b0, c_ADD, 64'd0, 64'd0);
        tick;   // c21: reset right after an issue
        chk("c21_busy",      {63'd0, busy_o}, 64'd1);
        rst = 1'b1;
        tick;   // c22
        chk("c22_in_ready",  {63'd0, in_ready}, 64'd0);
        chk("c22_level",     {61'd0, level_o}, 64'd0);
        chk("c22_issue",     {63'd0, issue_o}, 64'd0);
        chk("c22_a",         a_o, 64'd0);
        rst = 1'b0;
        force_cout = 1'b1;
        tick;   // c23
        chk("post_rst_level", {61'd0, level_o}, 64'd0);
        chk("post_rst_flag",  {63'd0, carry_flag_o}, 64'd0);
        chk("post_rst_busy",  {63'd0, busy_o}, 64'd0);
        chk("post_rst_ready", {63'd0, in_ready}, 64'd1);
        tick;   // c24
        chk("stale_cout_flag", {63'd0, carry_flag_o}, 64'd0);
        force_cout = 1'b0;
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
